// File: rtl/drink_order_master_if.sv
// Signal bundle between a drink_order_master, its order source and the vending
// machine: order request/response, wallet refill, machine select/coin/drink/back
// and wallet status.
interface drink_order_master_if #(
  parameter int CW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_drink;
  logic          refill_valid;
  logic [CW-1:0] refill_half;
  logic [CW-1:0] refill_one;
  logic [1:0]    select;
  logic [1:0]    coin;
  logic [1:0]    drink;
  logic [1:0]    back;
  logic          resp_valid;
  logic [1:0]    resp_drink;
  logic          resp_change;
  logic [1:0]    resp_err;
  logic          busy;
  logic [CW-1:0] half_cnt;
  logic [CW-1:0] one_cnt;

  // The order master drives the machine side and reports status.
  modport master (
    input  req_valid, req_drink, refill_valid, refill_half, refill_one,
    input  drink, back,
    output req_ready, select, coin, resp_valid, resp_drink, resp_change,
    output resp_err, busy, half_cnt, one_cnt
  );

  // The order source / machine model / bench side.
  modport slave (
    output req_valid, req_drink, refill_valid, refill_half, refill_one,
    output drink, back,
    input  req_ready, select, coin, resp_valid, resp_drink, resp_change,
    input  resp_err, busy, half_cnt, one_cnt
  );
endinterface

// File: rtl/drink_order_master.sv
// Customer-side initiator for the drink vending machine. Each accepted order is
// checked against the coin wallet, then played out as a select pulse followed by
// coin pulses separated by GAP idle cycles; the dispense response (or a timeout)
// completes it and any returned change is banked back into the wallet.
// Optional build macro DRINK_ORDER_STATS_EN adds saturating order statistics
// outputs stat_a / stat_b / stat_err.
module drink_order_master #(
  parameter int GAP       = 1,   // idle cycles between pulses, 1..15
  parameter int TIMEOUT   = 16,  // WAIT cycles before abort, 2..255
  parameter int INIT_HALF = 4,   // 0.5 coins after reset
  parameter int INIT_ONE  = 2,   // 1.0 coins after reset
  parameter int CW        = 4    // wallet counter width
) (
  input  logic clk,
  input  logic rst,
`ifdef DRINK_ORDER_STATS_EN
  output logic [7:0] stat_a,
  output logic [7:0] stat_b,
  output logic [7:0] stat_err,
`endif
  drink_order_master_if.master bus
);

  // Two spare bits: refill + change on a full counter cannot overflow.
  localparam int            SW      = CW + 2;
  localparam logic [SW-1:0] CNT_MAX = SW'((1 << CW) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_GAP, S_COIN, S_WAIT, S_DONE
  } state_t;

  state_t        r_state;
  logic          r_req_ready;
  logic          r_busy;
  logic [1:0]    r_select;
  logic [1:0]    r_coin;
  logic          r_resp_valid;
  logic [1:0]    r_resp_drink;
  logic          r_resp_change;
  logic [1:0]    r_resp_err;
  logic [CW-1:0] r_half_cnt;
  logic [CW-1:0] r_one_cnt;
  logic [1:0]    r_due;         // price still owed, in half-units
  logic [3:0]    r_gap_cnt;
  logic [7:0]    r_timer;
  logic          r_got_drink;   // machine response seen during this order
  logic [1:0]    r_got_code;
  logic          r_got_change;

  logic          w_drink_ok;
  logic [1:0]    w_price;
  logic [SW-1:0] w_funds;
  logic          w_gap_done;
  logic          w_use_one;
  logic          w_coin_fire;
  logic [1:0]    w_due_after;
  logic          w_change_in;
  logic [CW-1:0] w_refill_half;
  logic [CW-1:0] w_refill_one;
  logic [CW-1:0] w_half_next;
  logic [CW-1:0] w_one_next;
  logic          w_wait_hit;
  logic [1:0]    w_wait_code;
  logic          w_resp_change;

  // Net wallet update for one cycle: add refill and change, take one coin,
  // floor at zero, then saturate at the counter maximum.
  function automatic logic [CW-1:0] wallet_next(input logic [CW-1:0] cur,
                                                input logic [CW-1:0] add,
                                                input logic          inc,
                                                input logic          dec);
    logic [SW-1:0] sum;
    sum = SW'(cur) + SW'(add) + SW'(inc);
    if (dec && (sum != '0)) sum = sum - SW'(1);
    if (sum > CNT_MAX) sum = CNT_MAX;
    return sum[CW-1:0];
  endfunction

  assign w_drink_ok  = (bus.req_drink == 2'b01) || (bus.req_drink == 2'b10);
  assign w_price     = (bus.req_drink == 2'b01) ? 2'd2 : 2'd1;
  assign w_funds     = SW'(r_half_cnt) + (SW'(r_one_cnt) << 1);
  assign w_gap_done  = (r_gap_cnt == 4'(GAP - 1));

  // Prefer a 1.0 coin when at least a whole unit is owed; otherwise pay in
  // halves, falling back to an overpaying 1.0 coin when no halves are left.
  assign w_use_one   = ((r_due >= 2'd2) && (r_one_cnt != '0)) || (r_half_cnt == '0);
  assign w_coin_fire = (r_state == S_GAP) && w_gap_done && (r_due != 2'd0);
  assign w_due_after = w_use_one ? ((r_due >= 2'd2) ? r_due - 2'd2 : 2'd0)
                                 : r_due - 2'd1;

  assign w_change_in   = (r_state != S_IDLE) && (bus.back == 2'b01);
  assign w_refill_half = bus.refill_valid ? bus.refill_half : '0;
  assign w_refill_one  = bus.refill_valid ? bus.refill_one  : '0;
  assign w_half_next   = wallet_next(r_half_cnt, w_refill_half, w_change_in,
                                     w_coin_fire && !w_use_one);
  assign w_one_next    = wallet_next(r_one_cnt, w_refill_one, 1'b0,
                                     w_coin_fire && w_use_one);

  // A response latched earlier in the order counts as soon as WAIT is reached.
  assign w_wait_hit    = r_got_drink || (bus.drink != 2'b00);
  assign w_wait_code   = r_got_drink ? r_got_code : bus.drink;
  assign w_resp_change = r_got_change || w_change_in;

  // Order sequencer, wallet counters and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_req_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_select      <= 2'b00;
      r_coin        <= 2'b00;
      r_resp_valid  <= 1'b0;
      r_resp_drink  <= 2'b00;
      r_resp_change <= 1'b0;
      r_resp_err    <= 2'b00;
      r_half_cnt    <= CW'(INIT_HALF);
      r_one_cnt     <= CW'(INIT_ONE);
      r_due         <= 2'd0;
      r_gap_cnt     <= 4'd0;
      r_timer       <= 8'd0;
      r_got_drink   <= 1'b0;
      r_got_code    <= 2'b00;
      r_got_change  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every branch reads
      // the pre-edge register values regardless of statement order.
      r_half_cnt   <= w_half_next;
      r_one_cnt    <= w_one_next;
      r_resp_valid <= 1'b0;

      if (r_state != S_IDLE) begin
        if ((bus.drink != 2'b00) && !r_got_drink) begin
          r_got_drink <= 1'b1;
          r_got_code  <= bus.drink;
        end
        if (bus.back == 2'b01) r_got_change <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_req_ready  <= 1'b0;
            r_busy       <= 1'b1;
            r_got_drink  <= 1'b0;
            r_got_code   <= 2'b00;
            r_got_change <= 1'b0;
            if (!w_drink_ok || (w_funds < SW'(w_price))) begin
              r_state       <= S_DONE;
              r_resp_valid  <= 1'b1;
              r_resp_drink  <= 2'b00;
              r_resp_change <= 1'b0;
              r_resp_err    <= w_drink_ok ? 2'b01 : 2'b11;
            end else begin
              r_due    <= w_price;
              r_select <= bus.req_drink;
              r_state  <= S_SEL;
            end
          end
        end
        S_SEL: begin
          r_select  <= 2'b00;
          r_gap_cnt <= 4'd0;
          r_state   <= S_GAP;
        end
        S_GAP: begin
          if (!w_gap_done) begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
          end else if (r_due == 2'd0) begin
            r_timer <= 8'd0;
            r_state <= S_WAIT;
          end else begin
            r_coin  <= w_use_one ? 2'b10 : 2'b01;
            r_due   <= w_due_after;
            r_state <= S_COIN;
          end
        end
        S_COIN: begin
          r_coin    <= 2'b00;
          r_gap_cnt <= 4'd0;
          r_state   <= S_GAP;
        end
        S_WAIT: begin
          if (w_wait_hit) begin
            r_state       <= S_DONE;
            r_resp_valid  <= 1'b1;
            r_resp_drink  <= w_wait_code;
            r_resp_change <= w_resp_change;
            r_resp_err    <= 2'b00;
          end else if (r_timer == 8'(TIMEOUT - 1)) begin
            r_state       <= S_DONE;
            r_resp_valid  <= 1'b1;
            r_resp_drink  <= 2'b00;
            r_resp_change <= w_resp_change;
            r_resp_err    <= 2'b10;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        S_DONE: begin
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.busy        = r_busy;
  assign bus.select      = r_select;
  assign bus.coin        = r_coin;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_drink  = r_resp_drink;
  assign bus.resp_change = r_resp_change;
  assign bus.resp_err    = r_resp_err;
  assign bus.half_cnt    = r_half_cnt;
  assign bus.one_cnt     = r_one_cnt;

`ifdef DRINK_ORDER_STATS_EN
  logic [1:0] r_order;
  logic [7:0] r_stat_a;
  logic [7:0] r_stat_b;
  logic [7:0] r_stat_err;

  // Remember which drink the current order asked for.
  always_ff @(posedge clk) begin
    if (rst) r_order <= 2'b00;
    else if ((r_state == S_IDLE) && bus.req_valid && r_req_ready) r_order <= bus.req_drink;
  end

  // Tally each completion as its response pulse goes out, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_a   <= 8'd0;
      r_stat_b   <= 8'd0;
      r_stat_err <= 8'd0;
    end else if (r_resp_valid) begin
      if (r_resp_err != 2'b00) begin
        if (r_stat_err != 8'hFF) r_stat_err <= r_stat_err + 8'd1;
      end else if (r_order == 2'b01) begin
        if (r_stat_a != 8'hFF) r_stat_a <= r_stat_a + 8'd1;
      end else begin
        if (r_stat_b != 8'hFF) r_stat_b <= r_stat_b + 8'd1;
      end
    end
  end

  assign stat_a   = r_stat_a;
  assign stat_b   = r_stat_b;
  assign stat_err = r_stat_err;
`endif

endmodule

// File: tb/tb_drink_order_master.sv
// Bench for drink_order_master: directed scenarios followed by random orders,
// each checked cycle by cycle against an order-level model of the wallet, the
// pulse schedule and the response timing.
module tb_drink_order_master;

  localparam int GAP       = 1;
  localparam int TIMEOUT   = 16;
  localparam int INIT_HALF = 4;
  localparam int INIT_ONE  = 2;
  localparam int CW        = 4;
  localparam int CMAX      = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   m_half;
  int   m_one;
  logic [1:0] sel_exp  [0:127];
  logic [1:0] coin_exp [0:127];

  drink_order_master_if #(.CW(CW)) bus ();

  drink_order_master #(
    .GAP(GAP), .TIMEOUT(TIMEOUT), .INIT_HALF(INIT_HALF), .INIT_ONE(INIT_ONE), .CW(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : ((v < 0) ? 0 : v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    check("rst_ready", int'(bus.req_ready), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_select", int'(bus.select), 0);
    check("rst_coin", int'(bus.coin), 0);
    check("rst_resp_valid", int'(bus.resp_valid), 0);
    check("rst_half", int'(bus.half_cnt), INIT_HALF);
    check("rst_one", int'(bus.one_cnt), INIT_ONE);
    rst = 1'b0;
    m_half = INIT_HALF;
    m_one  = INIT_ONE;
  endtask

  task automatic refill(input int rh, input int ro);
    bus.refill_valid = 1'b1;
    bus.refill_half  = CW'(rh);
    bus.refill_one   = CW'(ro);
    step();
    bus.refill_valid = 1'b0;
    bus.refill_half  = '0;
    bus.refill_one   = '0;
    m_half = sat(m_half + rh);
    m_one  = sat(m_one + ro);
    check("refill_half", int'(bus.half_cnt), m_half);
    check("refill_one", int'(bus.one_cnt), m_one);
  endtask

  // One order: d = drink code, respond = machine answers, delay = cycles from
  // the last pulse to the machine's drink, rh/ro = refill issued with the request.
  task automatic run_order(input logic [1:0] d, input bit respond, input int delay,
                           input int rh, input int ro);
    int h, o, due, price, ncoin, paid, w, t, done, err;
    bit ok, chg;
    logic [1:0] rdrink;
    for (int i = 0; i < 128; i++) begin
      sel_exp[i]  = 2'b00;
      coin_exp[i] = 2'b00;
    end
    ok     = (d == 2'b01) || (d == 2'b10);
    price  = (d == 2'b01) ? 2 : 1;
    h      = sat(m_half + rh);
    o      = sat(m_one + ro);
    chg    = 1'b0;
    rdrink = 2'b00;
    t      = -1;
    if (!ok) begin
      err = 3; done = 1;
    end else if (m_half + 2 * m_one < price) begin
      err = 1; done = 1;
    end else begin
      sel_exp[1] = d;
      due = price; ncoin = 0; paid = 0;
      while (due > 0) begin
        ncoin++;
        if (due >= 2 && o > 0) begin
          coin_exp[1 + ncoin * (GAP + 1)] = 2'b10; o--; paid += 2; due -= 2;
        end else if (h > 0) begin
          coin_exp[1 + ncoin * (GAP + 1)] = 2'b01; h--; paid += 1; due -= 1;
        end else begin
          coin_exp[1 + ncoin * (GAP + 1)] = 2'b10; o--; paid += 2; due = 0;
        end
      end
      w = 1 + (ncoin + 1) * (GAP + 1);
      if (respond) begin
        t      = w - (GAP + 1) + delay;
        done   = ((t > w) ? t : w) + 1;
        err    = 0;
        rdrink = d;
        chg    = (paid > price);
        if (chg) h = sat(h + 1);
      end else begin
        done = w + TIMEOUT;
        err  = 2;
      end
    end

    bus.req_drink    = d;
    bus.req_valid    = 1'b1;
    bus.refill_valid = (rh != 0) || (ro != 0);
    bus.refill_half  = CW'(rh);
    bus.refill_one   = CW'(ro);
    for (int k = 1; k <= done + 1; k++) begin
      step();
      if (k == 1) begin
        bus.req_valid    = 1'b0;
        bus.refill_valid = 1'b0;
        bus.refill_half  = '0;
        bus.refill_one   = '0;
      end
      bus.drink = 2'b00;
      bus.back  = 2'b00;
      check("select", int'(bus.select), int'(sel_exp[k]));
      check("coin", int'(bus.coin), int'(coin_exp[k]));
      check("resp_valid", int'(bus.resp_valid), int'(k == done));
      check("busy", int'(bus.busy), int'(k <= done));
      check("req_ready", int'(bus.req_ready), int'(k > done));
      if (k == done) begin
        check("resp_err", int'(bus.resp_err), err);
        if (err == 0) begin
          check("resp_drink", int'(bus.resp_drink), int'(rdrink));
          check("resp_change", int'(bus.resp_change), int'(chg));
        end
        check("half_cnt", int'(bus.half_cnt), h);
        check("one_cnt", int'(bus.one_cnt), o);
      end
      if (k == done + 1) check("resp_err_hold", int'(bus.resp_err), err);
      if (respond && ok && (k == t)) begin
        bus.drink = d;
        if (chg) bus.back = 2'b01;
      end
    end
    m_half = h;
    m_one  = o;
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_drink    = 2'b00;
    bus.refill_valid = 1'b0;
    bus.refill_half  = '0;
    bus.refill_one   = '0;
    bus.drink        = 2'b00;
    bus.back         = 2'b00;
    do_reset();

    // Wallet 4/2, drink A, machine answers two cycles after the coin.
    run_order(2'b01, 1'b1, 2, 0, 0);
    check("tp1_half", int'(bus.half_cnt), 4);
    check("tp1_one", int'(bus.one_cnt), 1);

    // Walk the wallet down to 2/0, then pay A with two half coins.
    run_order(2'b01, 1'b1, 3, 0, 0);
    run_order(2'b10, 1'b1, 1, 0, 0);
    run_order(2'b10, 1'b1, 4, 0, 0);
    check("tp2_pre_half", int'(bus.half_cnt), 2);
    run_order(2'b01, 1'b1, 2, 0, 0);
    check("tp2_half", int'(bus.half_cnt), 0);
    check("tp2_one", int'(bus.one_cnt), 0);

    // Wallet 0/1, drink B overpays and gets change back.
    refill(0, 1);
    run_order(2'b10, 1'b1, 2, 0, 0);
    check("tp3_change", int'(bus.resp_change), 1);
    check("tp3_half", int'(bus.half_cnt), 1);
    check("tp3_one", int'(bus.one_cnt), 0);

    // Wallet 1/0 cannot pay for A.
    run_order(2'b01, 1'b1, 2, 0, 0);
    check("tp4_err", int'(bus.resp_err), 1);

    // B with a silent machine times out; then an invalid code.
    run_order(2'b10, 1'b0, 0, 0, 0);
    check("tp5_err", int'(bus.resp_err), 2);
    run_order(2'b11, 1'b1, 1, 0, 0);
    check("tp5_invalid", int'(bus.resp_err), 3);

    // Reset during the GAP of an order A abandons it silently.
    do_reset();
    bus.req_drink = 2'b01;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    check("mid_select", int'(bus.select), 1);
    step();
    check("mid_gap_coin", int'(bus.coin), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_select", int'(bus.select), 0);
    check("mid_rst_coin", int'(bus.coin), 0);
    check("mid_rst_half", int'(bus.half_cnt), INIT_HALF);
    check("mid_rst_one", int'(bus.one_cnt), INIT_ONE);
    for (int i = 0; i < 4; i++) begin
      check("mid_rst_no_resp", int'(bus.resp_valid), 0);
      step();
    end
    m_half = INIT_HALF;
    m_one  = INIT_ONE;
    run_order(2'b10, 1'b1, 3, 0, 0);

    // Wallet saturation.
    refill(15, 15);
    refill(3, 2);
    check("sat_half", int'(bus.half_cnt), CMAX);

    // Random orders with random refills and machine behaviour.
    for (int n = 0; n < 60; n++) begin
      int sel, rh, ro;
      logic [1:0] d;
      if ($urandom_range(0, 3) == 0) refill($urandom_range(0, 3), $urandom_range(0, 2));
      sel = $urandom_range(0, 9);
      d   = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b11 : (sel < 6) ? 2'b01 : 2'b10;
      rh  = 0;
      ro  = 0;
      if ($urandom_range(0, 4) == 0) begin
        rh = $urandom_range(0, 2);
        ro = $urandom_range(0, 2);
      end
      run_order(d, $urandom_range(0, 9) != 0, $urandom_range(1, GAP + TIMEOUT - 1), rh, ro);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/drink_order_master.md
Name: drink_order_master

Overview:
- Customer-side initiator for the drink vending machine interface; it drives `select` and `coin` and consumes the machine's `drink` and `back` responses.
- On each accepted order it:
  - checks that its coin wallet can pay;
  - issues a one-cycle `select` pulse, then one-cycle coin pulses separated by idle gaps;
  - waits for the dispense response;
  - banks any returned change into the wallet.
- Used as the bus-functional master in machine-level benches and as the order front end in the kiosk top level.

Parameters:
- `GAP`, 1: idle cycles between consecutive `select`/`coin` pulses (1..15).
- `TIMEOUT`, 16: cycles to wait for `drink` after the final coin before aborting (2..255).
- `INIT_HALF`, 4: number of 0.5 coins in the wallet after reset.
- `INIT_ONE`, 2: number of 1.0 coins in the wallet after reset.
- `CW`, 4: width of each wallet counter; counters saturate at 2^CW-1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  1  order request.
- `req_ready`  out  1  high only in IDLE.
- `req_drink`  in  2  01 = drink A (price 2 half-units), 10 = drink B (price 1 half-unit); 00/11 are invalid.
- `refill_valid`  in  1  add coins to the wallet.
- `refill_half`  in  CW  0.5 coins to add.
- `refill_one`  in  CW  1.0 coins to add.
- `select`  out  2  to machine, one-cycle pulse.
- `coin`  out  2  to machine; 01 = 0.5, 10 = 1.0; one-cycle pulse.
- `drink`  in  2  from machine, dispense code.
- `back`  in  2  from machine; 01 = 0.5 change returned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_drink`  out  2  drink received.
- `resp_change`  out  1  change was received.
- `resp_err`  out  2  00 ok, 01 insufficient funds, 10 timeout, 11 invalid drink.
- `busy`  out  1  high when not in IDLE.
- `half_cnt`  out  CW  current count of 0.5 coins.
- `one_cnt`  out  CW  current count of 1.0 coins.

Behaviour:

Reset:
- State goes to IDLE.
- `select`, `coin`, `resp_*` are 0; `busy` is 0; `req_ready` is 1.
- `half_cnt` = INIT_HALF, `one_cnt` = INIT_ONE.
- A reset mid-order abandons the order silently (no `resp_valid`).

States and transitions:
- IDLE:
  - Accept when `req_valid && req_ready`.
  - Invalid `req_drink` goes to DONE with err=11.
  - If funds (`half_cnt + 2*one_cnt`) < price, go to DONE with err=01; no `select` is issued.
  - Otherwise latch `due` = price and go to SEL.
- SEL: drive `select` = `req_drink` for 1 cycle, then go to GAP.
- GAP: hold `select`/`coin` at 00 for GAP cycles. If `due` == 0 go to WAIT, else go to COIN.
- COIN: drive one coin for 1 cycle and decrement its wallet counter, then go to GAP. Coin choice:
  - If `due` >= 2 and `one_cnt` > 0: use 1.0.
  - Else if `half_cnt` > 0: use 0.5.
  - Else use 1.0 (overpay; change expected).
  - `due` -= coin value in half-units, floored at 0.
- WAIT:
  - A timer counts up from 0 on entry.
  - A nonzero `drink` latches `resp_drink` and goes to DONE with err=00.
  - If the timer reaches TIMEOUT, go to DONE with err=10.
- DONE: `resp_valid` = 1 for one cycle, then IDLE. The `resp_*` fields hold until the next `resp_valid`.

Response sampling:
- `drink` and `back` are sampled in every non-IDLE state, so a response arriving during the final GAP is not lost.
- `back` == 01 sets `resp_change` and increments `half_cnt`.
- A `drink` response seen before WAIT is latched; WAIT then exits on its first cycle.

Wallet arithmetic:
- All wallet arithmetic saturates at 2^CW-1 and floors at 0.
- `refill_valid` is honoured in any state.
- Refill, change return and coin spend in the same cycle are all applied (net sum, then saturate).

Request handling:
- A `req_valid` while busy is ignored (`req_ready` = 0).
- `select` and `coin` are never nonzero in the same cycle.

Optional Feature:
- Macro: `DRINK_ORDER_STATS_EN`.
- Defined:
  - Adds outputs `stat_a`, `stat_b`, `stat_err` (8 bits each).
  - `stat_a`/`stat_b` count successful A/B orders; `stat_err` counts `resp_valid` with err != 00.
  - All three saturate at 255 and are cleared by `rst`.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Wallet 4/2, order A, machine dispenses 01 two cycles after the coin:
  - Sequence is `select`=01, one idle cycle, `coin`=10.
  - Response: `resp_drink`=01, err 00.
  - Wallet ends at 4/1.
- Wallet 2/0, order A:
  - Coins 01, gap, 01.
  - Response: `resp_drink`=01.
  - Wallet ends at 0/0.
- Wallet 0/1, order B, machine returns `drink`=10 and `back`=01:
  - Single `coin`=10.
  - `resp_change`=1.
  - Wallet ends at 1/0.
- Wallet 1/0, order A:
  - No `select` or `coin` pulse is issued.
  - `resp_valid` with err=01 one cycle after accept.
- Order B, machine never responds:
  - `resp_valid` with err=10 exactly TIMEOUT cycles after WAIT entry.
  - Then `req_drink`=11 gives err=11.
- Assert `rst` during GAP of an order A:
  - Next cycle `select`/`coin` = 00 and there is no `resp_valid`.
  - Wallet is 4/2.
  - A subsequent order B completes normally.
